plic_claim_arbiter: RTL and testbench

//  Platform-interrupt core sitting between N level gateways and the hart.

---
 rtl/plic_claim_arbiter_pkg.sv | 22 ++
 rtl/plic_claim_arbiter_if.sv | 40 ++++
 rtl/plic_prio_max.sv | 50 +++++
 rtl/plic_claim_arbiter.sv | 88 ++++++++
 tb/tb_plic_claim_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/plic_claim_arbiter_pkg.sv
// ============================================================================
// plic_claim_arbiter_pkg : shared ID/priority definitions for the PLIC core
// Revision: 1.0
// ============================================================================
`default_nettype none

package plic_claim_arbiter_pkg;

   localparam int DEF_NSRC   = 8;
   localparam int DEF_PRIO_W = 3;
   localparam int ID_NONE    = 0;

   typedef logic [DEF_PRIO_W-1:0] prio_t;

   // IDs run 1..nsrc with 0 reserved for "none", hence the +1.
   function automatic int id_width(input int nsrc);
      return $clog2(nsrc + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/plic_claim_arbiter_if.sv
// ============================================================================
// plic_claim_arbiter_if : gateway, priority and hart claim/complete signals
// Revision: 1.0
// ============================================================================
`default_nettype none

interface plic_claim_arbiter_if
   import plic_claim_arbiter_pkg::*;
#(
   parameter int NSRC   = DEF_NSRC,
   parameter int PRIO_W = DEF_PRIO_W
);
   localparam int ID_W = id_width(NSRC);

   logic [NSRC-1:0]        io_gw_valid;
   logic [NSRC-1:0]        io_gw_ready;
   logic [NSRC-1:0]        io_gw_complete;
   logic [NSRC*PRIO_W-1:0] io_prio;
   logic [PRIO_W-1:0]      io_threshold;
   logic                   io_irq;
   logic                   io_claim_req;
   logic [ID_W-1:0]        io_claim_id;
   logic                   io_complete_valid;
   logic [ID_W-1:0]        io_complete_id;

   modport master (
      output io_gw_valid, io_prio, io_threshold, io_claim_req,
             io_complete_valid, io_complete_id,
      input  io_gw_ready, io_gw_complete, io_irq, io_claim_id
   );

   modport slave (
      input  io_gw_valid, io_prio, io_threshold, io_claim_req,
             io_complete_valid, io_complete_id,
      output io_gw_ready, io_gw_complete, io_irq, io_claim_id
   );

endinterface

`default_nettype wire

// File: rtl/plic_prio_max.sv
// ============================================================================
// plic_prio_max : balanced compare tree returning highest-priority valid ID
// Revision: 1.0
// ============================================================================
`default_nettype none

module plic_prio_max
   import plic_claim_arbiter_pkg::*;
#(
   parameter int NSRC   = DEF_NSRC,
   parameter int PRIO_W = DEF_PRIO_W,
   parameter int ID_W   = id_width(NSRC)
) (
   input  logic [NSRC-1:0]        valid,
   input  logic [NSRC*PRIO_W-1:0] prio,
   output logic [ID_W-1:0]        max_id,
   output logic [PRIO_W-1:0]      max_prio
);

   localparam int LEVELS = (NSRC > 1) ? $clog2(NSRC) : 0;
   localparam int LEAVES = 1 << LEVELS;

   // Heap layout: node n has children 2n and 2n+1, leaves start at LEAVES.
   logic [ID_W-1:0]   w_node_id   [1:2*LEAVES-1];
   logic [PRIO_W-1:0] w_node_prio [1:2*LEAVES-1];

   for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
      if (i < NSRC) begin : g_src
         assign w_node_id[LEAVES+i]   = valid[i] ? ID_W'(i + 1) : '0;
         assign w_node_prio[LEAVES+i] = valid[i] ? prio[(i+1)*PRIO_W-1 -: PRIO_W] : '0;
      end else begin : g_pad
         assign w_node_id[LEAVES+i]   = '0;
         assign w_node_prio[LEAVES+i] = '0;
      end
   end

   // Left subtree always holds lower IDs, so a strict compare breaks ties low.
   for (genvar n = 1; n < LEAVES; n++) begin : g_node
      logic w_take_right;
      assign w_take_right   = w_node_prio[2*n+1] > w_node_prio[2*n];
      assign w_node_id[n]   = w_take_right ? w_node_id[2*n+1]   : w_node_id[2*n];
      assign w_node_prio[n] = w_take_right ? w_node_prio[2*n+1] : w_node_prio[2*n];
   end

   assign max_id   = w_node_id[1];
   assign max_prio = w_node_prio[1];

endmodule

`default_nettype wire

// File: rtl/plic_claim_arbiter.sv
// ============================================================================
// plic_claim_arbiter : pending/claimed tracking, select, claim and complete
// Revision: 1.0
// ============================================================================
`default_nettype none

module plic_claim_arbiter
   import plic_claim_arbiter_pkg::*;
#(
   parameter int NSRC   = DEF_NSRC,
   parameter int PRIO_W = DEF_PRIO_W
) (
   input  logic                 clk,
   input  logic                 reset,
   plic_claim_arbiter_if.slave  bus
);

   localparam int ID_W = id_width(NSRC);

   logic [NSRC-1:0]   r_pending;
   logic [NSRC-1:0]   r_claimed;
   logic [NSRC-1:0]   r_gw_complete;
   logic [ID_W-1:0]   r_best_id;
   logic              r_irq;

   logic [NSRC-1:0]   w_ready;
   logic [NSRC-1:0]   w_accept;
   logic [NSRC-1:0]   w_eligible;
   logic [NSRC-1:0]   w_claim_mask;
   logic [NSRC-1:0]   w_cpl_mask;
   logic              w_claim_hit;
   logic [ID_W-1:0]   w_max_id;
   logic [PRIO_W-1:0] w_max_prio;

   assign w_ready     = ~r_pending & ~r_claimed;
   assign w_accept    = bus.io_gw_valid & w_ready;
   assign w_claim_hit = bus.io_claim_req & (r_best_id != ID_W'(ID_NONE));

   for (genvar i = 0; i < NSRC; i++) begin : g_src
      assign w_eligible[i]   = r_pending[i] &
                               (bus.io_prio[(i+1)*PRIO_W-1 -: PRIO_W] > bus.io_threshold);
      assign w_claim_mask[i] = w_claim_hit & (r_best_id == ID_W'(i + 1));
      assign w_cpl_mask[i]   = bus.io_complete_valid &
                               (bus.io_complete_id == ID_W'(i + 1)) & r_claimed[i];
   end

   plic_prio_max #(
      .NSRC   (NSRC),
      .PRIO_W (PRIO_W),
      .ID_W   (ID_W)
   ) u_prio_max (
      .valid    (w_eligible),
      .prio     (bus.io_prio),
      .max_id   (w_max_id),
      .max_prio (w_max_prio)
   );

   // A winner always has prio > threshold >= 0, so nonzero prio <=> nonzero ID.
   // The claim edge zeroes the select because it was computed from stale pending.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pending     <= '0;
         r_claimed     <= '0;
         r_gw_complete <= '0;
         r_best_id     <= ID_W'(ID_NONE);
         r_irq         <= 1'b0;
      end else begin
         r_pending     <= (r_pending | w_accept) & ~w_claim_mask;
         r_claimed     <= (r_claimed | w_claim_mask) & ~w_cpl_mask;
         r_gw_complete <= w_cpl_mask;
         if (w_claim_hit) begin
            r_best_id <= ID_W'(ID_NONE);
            r_irq     <= 1'b0;
         end else begin
            r_best_id <= w_max_id;
            r_irq     <= (w_max_prio != '0);
         end
      end
   end

   assign bus.io_gw_ready    = w_ready;
   assign bus.io_gw_complete = r_gw_complete;
   assign bus.io_irq         = r_irq;
   assign bus.io_claim_id    = r_best_id;

endmodule

`default_nettype wire

// File: tb/tb_plic_claim_arbiter.sv
// ============================================================================
// tb_plic_claim_arbiter : directed stimulus checked against a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_plic_claim_arbiter;
   import plic_claim_arbiter_pkg::*;

   localparam int NSRC   = 8;
   localparam int PRIO_W = 3;
   localparam int ID_W   = id_width(NSRC);

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   bad_ids [4] = '{0, 9, 1, 6};

   plic_claim_arbiter_if #(.NSRC(NSRC), .PRIO_W(PRIO_W)) bus ();

   plic_claim_arbiter #(.NSRC(NSRC), .PRIO_W(PRIO_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic pin(input string name, input logic [31:0] dut_v,
                      input logic [31:0] mdl_v, input logic [31:0] lit);
      check({name, " dut"}, dut_v, lit);
      check({name, " model"}, mdl_v, lit);
   endtask

   // ---------------- behavioural model (IDs 1..NSRC) ----------------
   bit m_pend [1:NSRC];
   bit m_clm  [1:NSRC];
   bit m_gwc  [1:NSRC];
   int m_best;
   bit m_irq;

   function automatic int prio_of(input int id);
      prio_t p;
      p = bus.io_prio[id*PRIO_W-1 -: PRIO_W];
      return int'(p);
   endfunction

   function automatic logic [NSRC-1:0] m_ready();
      logic [NSRC-1:0] r;
      for (int i = 1; i <= NSRC; i++) r[i-1] = !m_pend[i] && !m_clm[i];
      return r;
   endfunction

   function automatic logic [NSRC-1:0] m_gwc_vec();
      logic [NSRC-1:0] r;
      for (int i = 1; i <= NSRC; i++) r[i-1] = m_gwc[i];
      return r;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i <= NSRC; i++) begin
            m_pend[i] = 0; m_clm[i] = 0; m_gwc[i] = 0;
         end
         m_best = 0;
         m_irq  = 0;
      end else begin
         int sel_id, sel_p, thr, cid;
         bit acc [1:NSRC];
         sel_id = 0; sel_p = 0;
         thr = int'(bus.io_threshold);
         for (int id = 1; id <= NSRC; id++)
            if (m_pend[id] && prio_of(id) > thr && prio_of(id) > sel_p) begin
               sel_id = id; sel_p = prio_of(id);
            end
         for (int id = 1; id <= NSRC; id++) begin
            acc[id]   = bus.io_gw_valid[id-1] && !m_pend[id] && !m_clm[id];
            m_gwc[id] = 0;
         end
         cid = int'(bus.io_complete_id);
         if (bus.io_complete_valid && cid >= 1 && cid <= NSRC && m_clm[cid]) begin
            m_clm[cid] = 0; m_gwc[cid] = 1;
         end
         if (bus.io_claim_req && m_best != 0) begin
            m_pend[m_best] = 0; m_clm[m_best] = 1; m_best = 0; m_irq = 0;
         end else begin
            m_best = sel_id; m_irq = (sel_id != 0);
         end
         for (int id = 1; id <= NSRC; id++) if (acc[id]) m_pend[id] = 1;
      end
   end

   always @(negedge clk) begin
      check("irq", 32'(bus.io_irq), 32'(m_irq));
      check("claim_id", 32'(bus.io_claim_id), m_best);
      check("gw_ready", 32'(bus.io_gw_ready), 32'(m_ready()));
      check("gw_complete", 32'(bus.io_gw_complete), 32'(m_gwc_vec()));
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_prio(input int id, input int p);
      bus.io_prio[id*PRIO_W-1 -: PRIO_W] = PRIO_W'(p);
   endtask

   task automatic pulse_valid(input logic [NSRC-1:0] v);
      bus.io_gw_valid = v;
      @(negedge clk);
      bus.io_gw_valid = '0;
   endtask

   task automatic strobe(input bit do_claim, input int exp_id, input bit do_cpl, input int cpl_id);
      bus.io_claim_req      = do_claim;
      bus.io_complete_valid = do_cpl;
      bus.io_complete_id    = ID_W'(cpl_id);
      #1;
      if (do_claim) pin("claim returns", 32'(bus.io_claim_id), m_best, exp_id);
      @(negedge clk);
      bus.io_claim_req      = 1'b0;
      bus.io_complete_valid = 1'b0;
      bus.io_complete_id    = '0;
   endtask

   initial begin
      bus.io_gw_valid       = '0;
      bus.io_prio           = '0;
      bus.io_threshold      = '0;
      bus.io_claim_req      = 1'b0;
      bus.io_complete_valid = 1'b0;
      bus.io_complete_id    = '0;
      #1 reset = 1'b1;
      idle(3);
      reset = 1'b0;
      pin("reset irq", 32'(bus.io_irq), 32'(m_irq), 0);
      pin("reset ready", 32'(bus.io_gw_ready), 32'(m_ready()), 32'hFF);
      strobe(1, 0, 0, 0);

      // single source
      bus.io_threshold = 3'd2;
      set_prio(3, 5);
      pulse_valid(8'h04);
      pin("single irq early", 32'(bus.io_irq), 32'(m_irq), 0);
      pin("single ready pend", 32'(bus.io_gw_ready), 32'(m_ready()), 32'hFB);
      idle(1);
      pin("single irq", 32'(bus.io_irq), 32'(m_irq), 1);
      strobe(1, 3, 0, 0);
      pin("claim guard irq", 32'(bus.io_irq), 32'(m_irq), 0);
      pin("claimed ready", 32'(bus.io_gw_ready), 32'(m_ready()), 32'hFB);
      idle(1);
      strobe(0, 0, 1, 3);
      pin("single gw_complete", 32'(bus.io_gw_complete), 32'(m_gwc_vec()), 32'h04);
      pin("single ready back", 32'(bus.io_gw_ready), 32'(m_ready()), 32'hFF);
      idle(1);
      pin("gw_complete 1 cycle", 32'(bus.io_gw_complete), 32'(m_gwc_vec()), 0);

      // arbitration with claim+complete overlap
      set_prio(3, 0); set_prio(2, 4); set_prio(5, 6); set_prio(7, 6);
      pulse_valid(8'h52);
      idle(1);
      pin("arb irq", 32'(bus.io_irq), 32'(m_irq), 1);
      strobe(1, 5, 0, 0);
      idle(1);
      strobe(1, 7, 1, 5);
      pin("arb cpl 5", 32'(bus.io_gw_complete), 32'(m_gwc_vec()), 32'h10);
      idle(1);
      strobe(1, 2, 1, 7);
      pin("arb cpl 7", 32'(bus.io_gw_complete), 32'(m_gwc_vec()), 32'h40);
      idle(1);
      pin("arb drained irq", 32'(bus.io_irq), 32'(m_irq), 0);
      strobe(1, 0, 1, 2);
      pin("arb cpl 2", 32'(bus.io_gw_complete), 32'(m_gwc_vec()), 32'h02);
      pin("arb ready", 32'(bus.io_gw_ready), 32'(m_ready()), 32'hFF);

      // threshold
      set_prio(2, 0); set_prio(5, 0); set_prio(7, 0); set_prio(4, 3);
      bus.io_threshold = 3'd3;
      pulse_valid(8'h08);
      idle(2);
      pin("thr blocks irq", 32'(bus.io_irq), 32'(m_irq), 0);
      pin("thr still pending", 32'(bus.io_gw_ready), 32'(m_ready()), 32'hF7);
      bus.io_threshold = 3'd2;
      idle(1);
      pin("thr lowered irq", 32'(bus.io_irq), 32'(m_irq), 1);
      strobe(1, 4, 0, 0);
      idle(1);
      strobe(0, 0, 1, 4);
      pin("thr cpl 4", 32'(bus.io_gw_complete), 32'(m_gwc_vec()), 32'h08);

      // bad completes: src 8 claimed, src 6 merely pending (below threshold)
      set_prio(4, 0); set_prio(6, 1); set_prio(8, 7);
      pulse_valid(8'hA0);
      idle(1);
      strobe(1, 8, 0, 0);
      pin("bad setup ready", 32'(bus.io_gw_ready), 32'(m_ready()), 32'h5F);
      for (int k = 0; k < 4; k++) begin
         strobe(0, 0, 1, bad_ids[k]);
         pin("bad cpl none", 32'(bus.io_gw_complete), 32'(m_gwc_vec()), 0);
         pin("bad cpl ready", 32'(bus.io_gw_ready), 32'(m_ready()), 32'h5F);
      end
      strobe(0, 0, 1, 8);
      pin("good cpl 8", 32'(bus.io_gw_complete), 32'(m_gwc_vec()), 32'h80);
      pin("good cpl ready", 32'(bus.io_gw_ready), 32'(m_ready()), 32'hDF);

      // async reset between claim and complete
      set_prio(1, 7);
      pulse_valid(8'h01);
      idle(1);
      strobe(1, 1, 0, 0);
      pin("pre-reset ready", 32'(bus.io_gw_ready), 32'(m_ready()), 32'hDE);
      #2 reset = 1'b1;
      #1;
      pin("async ready", 32'(bus.io_gw_ready), 32'(m_ready()), 32'hFF);
      pin("async irq", 32'(bus.io_irq), 32'(m_irq), 0);
      pin("async claim_id", 32'(bus.io_claim_id), m_best, 0);
      @(negedge clk);
      reset = 1'b0;
      strobe(0, 0, 1, 1);
      pin("stale cpl ignored", 32'(bus.io_gw_complete), 32'(m_gwc_vec()), 0);
      pin("stale cpl ready", 32'(bus.io_gw_ready), 32'(m_ready()), 32'hFF);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1);
   end

endmodule

`default_nettype wire
